mode_switch_n: RTL

//  Parametrised top-level mode sequencer for the piano: N_MODES play modes (auto, free, learn, record, ...).

---
 rtl/mode_switch_n_pkg.sv | 36 +++
 rtl/mode_switch_n_menu_disp.sv | 17 +
 rtl/mode_switch_n.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mode_switch_n_pkg.sv
// Shared definitions for the piano mode sequencer: state encoding, 7-seg digit table, bus width defaults.
package mode_switch_n_pkg;

  localparam int LED_W_DEF = 8;
  localparam int SEG_W_DEF = 8;

  typedef enum logic {
    ST_MENU   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Active-high segments, bit order {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'h0: code = 8'h3F;
      4'h1: code = 8'h06;
      4'h2: code = 8'h5B;
      4'h3: code = 8'h4F;
      4'h4: code = 8'h66;
      4'h5: code = 8'h6D;
      4'h6: code = 8'h7D;
      4'h7: code = 8'h07;
      4'h8: code = 8'h7F;
      4'h9: code = 8'h6F;
      4'hA: code = 8'h77;
      4'hB: code = 8'h7C;
      4'hC: code = 8'h39;
      4'hD: code = 8'h5E;
      4'hE: code = 8'h79;
      default: code = 8'h71;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mode_switch_n_menu_disp.sv
// Menu display: shows the cursor as one hex digit on the rightmost digit of the left bank.
module mode_menu_disp
  import mode_switch_n_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic [3:0]       i_cursor,
  output logic [SEG_W-1:0] o_seg_en,
  output logic [SEG_W-1:0] o_seg_sel_l,
  output logic [SEG_W-1:0] o_seg_sel_r
);

  assign o_seg_en    = SEG_W'(1);
  assign o_seg_sel_l = SEG_W'(seg_code(i_cursor));
  assign o_seg_sel_r = '0;

endmodule

// File: rtl/mode_switch_n.sv
// Top-level play-mode sequencer: menu cursor, one-hot mode enables and registered output routing.
// Optional build macro MODE_TIMEOUT_EN adds an idle timeout that returns ACTIVE to MENU.
module mode_switch_n
  import mode_switch_n_pkg::*;
#(
  parameter int          N_MODES = 4,
  parameter int          LED_W   = LED_W_DEF,
  parameter int          SEG_W   = SEG_W_DEF,
  parameter int unsigned TIMEOUT = 100000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_c,
  input  logic                     btn_l,
  input  logic                     btn_r,
  input  logic [N_MODES*LED_W-1:0] m_bg_led,
  input  logic [N_MODES*LED_W-1:0] m_sm_led,
  input  logic [N_MODES*SEG_W-1:0] m_seg_en,
  input  logic [N_MODES*SEG_W-1:0] m_seg_l,
  input  logic [N_MODES*SEG_W-1:0] m_seg_r,
  input  logic [N_MODES-1:0]       m_pwm,
  output logic                     en_top,
  output logic [N_MODES-1:0]       en_mode,
  output logic [3:0]               cursor,
  output logic [LED_W-1:0]         bg_led,
  output logic [LED_W-1:0]         sm_led,
  output logic [SEG_W-1:0]         seg_en,
  output logic [SEG_W-1:0]         seg_sel_l,
  output logic [SEG_W-1:0]         seg_sel_r,
  output logic                     pwm,
  output logic                     sd
);

  state_t     r_state, w_state_nx;
  logic [3:0] r_cursor, w_cursor_nx;
  logic [2:0] r_btn_prev;
  logic       w_edge_c, w_edge_l, w_edge_r, w_any_edge, w_timeout;

  assign w_edge_c   = btn_c & ~r_btn_prev[0];
  assign w_edge_l   = btn_l & ~r_btn_prev[1];
  assign w_edge_r   = btn_r & ~r_btn_prev[2];
  assign w_any_edge = w_edge_c | w_edge_l | w_edge_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_MENU;
      r_cursor   <= 4'd0;
      r_btn_prev <= 3'b000;
    end else begin
      r_state    <= w_state_nx;
      r_cursor   <= w_cursor_nx;
      r_btn_prev <= {btn_r, btn_l, btn_c};
    end
  end

  // Right wins over left over center; a right press on cursor 0 is swallowed entirely.
  always_comb begin
    w_state_nx  = r_state;
    w_cursor_nx = r_cursor;
    case (r_state)
      ST_MENU: begin
        if (w_edge_r) begin
          if (r_cursor != 4'd0) w_state_nx = ST_ACTIVE;
        end else if (w_edge_l) begin
          w_cursor_nx = 4'd0;
        end else if (w_edge_c) begin
          w_cursor_nx = (r_cursor == 4'(N_MODES)) ? 4'd0 : r_cursor + 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (w_edge_r || w_timeout) w_state_nx = ST_MENU;
      end
      default: w_state_nx = ST_MENU;
    endcase
  end

`ifdef MODE_TIMEOUT_EN
  logic [31:0] r_idle;

  assign w_timeout = (r_state == ST_ACTIVE) && !w_any_edge && (r_idle >= TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (r_state != ST_ACTIVE || w_any_edge || w_timeout) begin
      r_idle <= '0;
    end else if (r_idle != '1) begin
      r_idle <= r_idle + 32'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^32'(TIMEOUT) ^ w_any_edge;
`endif

  // Enables decode straight from registers so an async reset drops them immediately.
  always_comb begin
    en_mode = '0;
    if (r_state == ST_ACTIVE) begin
      for (int k = 0; k < N_MODES; k++) begin
        if (r_cursor == 4'(k + 1)) en_mode[k] = 1'b1;
      end
    end
  end

  assign en_top = (r_state == ST_MENU);
  assign cursor = r_cursor;
  assign sd     = 1'b1;

  logic [LED_W-1:0] w_bg, w_sm;
  logic [SEG_W-1:0] w_sen, w_sl, w_sr;
  logic             w_pwm;

  always_comb begin
    w_bg  = '0;
    w_sm  = '0;
    w_sen = '0;
    w_sl  = '0;
    w_sr  = '0;
    w_pwm = 1'b0;
    for (int k = 0; k < N_MODES; k++) begin
      if (r_cursor == 4'(k + 1)) begin
        w_bg  = m_bg_led[k*LED_W +: LED_W];
        w_sm  = m_sm_led[k*LED_W +: LED_W];
        w_sen = m_seg_en[k*SEG_W +: SEG_W];
        w_sl  = m_seg_l[k*SEG_W +: SEG_W];
        w_sr  = m_seg_r[k*SEG_W +: SEG_W];
        w_pwm = m_pwm[k];
      end
    end
  end

  logic [SEG_W-1:0] w_menu_en, w_menu_l, w_menu_r;

  mode_menu_disp #(.SEG_W(SEG_W)) u_menu_disp (
    .i_cursor    (r_cursor),
    .o_seg_en    (w_menu_en),
    .o_seg_sel_l (w_menu_l),
    .o_seg_sel_r (w_menu_r)
  );

  logic [LED_W-1:0] r_bg, r_sm;
  logic [SEG_W-1:0] r_sen, r_sl, r_sr;
  logic             r_pwm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bg  <= '0;
      r_sm  <= '0;
      r_sen <= '0;
      r_sl  <= '0;
      r_sr  <= '0;
      r_pwm <= 1'b1;
    end else if (r_state == ST_ACTIVE) begin
      r_bg  <= w_bg;
      r_sm  <= w_sm;
      r_sen <= w_sen;
      r_sl  <= w_sl;
      r_sr  <= w_sr;
      r_pwm <= w_pwm;
    end else begin
      r_bg  <= '0;
      r_sm  <= '0;
      r_sen <= w_menu_en;
      r_sl  <= w_menu_l;
      r_sr  <= w_menu_r;
      r_pwm <= 1'b1;
    end
  end

  assign bg_led    = r_bg;
  assign sm_led    = r_sm;
  assign seg_en    = r_sen;
  assign seg_sel_l = r_sl;
  assign seg_sel_r = r_sr;
  assign pwm       = r_pwm;

endmodule
